// File: rtl/dpram_arbiter_pkg.sv
// Shared types for the two-requester DPRAM port-A arbiter: FSM state
// encoding and requester index constants.
package dpram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way grant: round-robin on last_gnt by default, or m0-first
// when DPRAM_ARBITER_FIXED_PRIO_EN is defined.
module rr_arb2
  import dpram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_o
);

`ifdef DPRAM_ARBITER_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

  always_comb begin
    gnt_o = M0;
    if (req_i == 2'b11) begin
`ifdef DPRAM_ARBITER_FIXED_PRIO_EN
      gnt_o = M0;
`else
      gnt_o = ~last_gnt_i;
`endif
    end else if (req_i[1]) begin
      gnt_o = M1;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates two requesters onto RAM port A: IDLE -> ISSUE -> RESP.
// Build option DPRAM_ARBITER_FIXED_PRIO_EN selects fixed m0 priority.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int ADR_WIDTH = 13,
  parameter int DAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADR_WIDTH-1:0] m0_adr,
  input  logic [DAT_WIDTH-1:0] m0_dat_w,
  output logic                 m0_ack,
  output logic [DAT_WIDTH-1:0] m0_dat_r,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADR_WIDTH-1:0] m1_adr,
  input  logic [DAT_WIDTH-1:0] m1_dat_w,
  output logic                 m1_ack,
  output logic [DAT_WIDTH-1:0] m1_dat_r,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADR_WIDTH-1:0] ram_adr,
  output logic [DAT_WIDTH-1:0] ram_dat_w,
  input  logic [DAT_WIDTH-1:0] ram_dat_r,
  output logic                 busy
);

  state_e               state_q;
  logic                 idx_q;
  logic                 last_gnt_q;
  logic                 we_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_w_q;
  logic                 ram_en_q;
  logic                 ram_we_q;
  logic [1:0]           ack_q;
  logic [DAT_WIDTH-1:0] dat_r0_q;
  logic [DAT_WIDTH-1:0] dat_r1_q;
  logic                 busy_q;

  logic                 gnt_d;
  logic                 we_d;
  logic [ADR_WIDTH-1:0] adr_d;
  logic [DAT_WIDTH-1:0] dat_w_d;

  rr_arb2 u_arb (
    .req_i      ({m1_req, m0_req}),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt_d)
  );

  assign we_d    = (gnt_d == M1) ? m1_we    : m0_we;
  assign adr_d   = (gnt_d == M1) ? m1_adr   : m0_adr;
  assign dat_w_d = (gnt_d == M1) ? m1_dat_w : m0_dat_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= M0;
      last_gnt_q <= M1;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_w_q    <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ack_q      <= '0;
      dat_r0_q   <= '0;
      dat_r1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q    <= ISSUE;
            idx_q      <= gnt_d;
            last_gnt_q <= gnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_w_q    <= dat_w_d;
            ram_en_q   <= 1'b1;
            ram_we_q   <= we_d;
            busy_q     <= 1'b1;
          end
        end
        ISSUE: begin
          state_q      <= RESP;
          ram_en_q     <= 1'b0;
          ram_we_q     <= 1'b0;
          ack_q[idx_q] <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          // RAM read data is valid this cycle; capture it so dat_r holds afterwards
          if (!we_q) begin
            if (idx_q == M1) dat_r1_q <= ram_dat_r;
            else             dat_r0_q <= ram_dat_r;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  // During the ack cycle of a read the captured register is not loaded yet
  assign m0_dat_r  = (ack_q[0] && !we_q) ? ram_dat_r : dat_r0_q;
  assign m1_dat_r  = (ack_q[1] && !we_q) ? ram_dat_r : dat_r1_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_adr   = adr_q;
  assign ram_dat_w = dat_w_q;
  assign busy      = busy_q;

endmodule
